latch_bank_writer: RTL and testbench



---
 rtl/latch_bank_writer.sv | 206 ++++++++++++++++++++
 tb/tb_latch_bank_writer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/latch_bank_writer.sv
// latch_bank_writer
// Write sequencer for a bank of DEPTH x WIDTH high-transparent latch words
// whose RESET_B input clears them when low. Requests arrive on a
// valid/ready handshake. Each write produces registered, glitch-free D and
// GATE waveforms with separate setup, pulse and hold phases. A clear request
// pulls the shared RESET_B low for PULSE_CYC cycles.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous, active-high reset (clears the bank)
//   req_valid      write request valid
//   req_ready      high only while idle
//   req_addr       target latch word
//   req_data       data to write
//   clr_req        clear all latch words; sampled only while idle, and wins
//                  over req_valid in the same cycle
//   latch_d        shared D bus; changes only when a request is accepted
//   latch_gate     one-hot GATE lines
//   latch_reset_b  shared active-low RESET_B
//   done           one-cycle pulse when a write or clear completes
//
// Optional feature (macro LATCH_BANK_WRITER_VERIFY_EN):
//   latch_q        read-back of all words (word i at bits i*WIDTH +: WIDTH)
//   verify_err     sticky error flag. It is set by a read-back mismatch on
//                  the last HOLD cycle, or by a nonzero word when a clear
//                  completes. It is cleared by rst or by a clean clear.
module latch_bank_writer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 4,
    parameter int ADDR_W    = 2,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WIDTH-1:0]  req_data,
    input  logic              clr_req,
    output logic [WIDTH-1:0]  latch_d,
    output logic [DEPTH-1:0]  latch_gate,
    output logic              latch_reset_b,
`ifdef LATCH_BANK_WRITER_VERIFY_EN
    input  logic [DEPTH*WIDTH-1:0] latch_q,
    output logic                   verify_err,
`endif
    output logic              done
);

    localparam int MAX_SP  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    // The counter holds (phase length - 1), so it needs clog2(MAX_CYC) bits,
    // with a minimum of 1 bit.
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        PULSE = 3'd2,
        HOLD  = 3'd3,
        CLEAR = 3'd4
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_s;
    logic               accept_s;
    logic               done_s;
    logic [ADDR_W-1:0]  addr_r;
    logic [DEPTH-1:0]   dec_s;

    // Next-state and phase-counter logic; the counter reloads on every state entry.
    always_comb begin
        state_s  = state_r;
        cnt_s    = cnt_r;
        accept_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (clr_req) begin
                    state_s = CLEAR;
                    cnt_s   = PULSE_LD;
                end else if (req_valid) begin
                    accept_s = 1'b1;
                    state_s  = SETUP;
                    cnt_s    = SETUP_LD;
                end else begin
                    cnt_s = {CNT_W{1'b0}};
                end
            end
            SETUP: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = PULSE;
                    cnt_s   = PULSE_LD;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            PULSE: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = HOLD;
                    cnt_s   = HOLD_LD;
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            HOLD, CLEAR: begin
                if (cnt_r == {CNT_W{1'b0}}) begin
                    state_s = IDLE;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Completion pulse: leaving HOLD or CLEAR for IDLE.
    always_comb begin
        if (((state_r == HOLD) || (state_r == CLEAR)) && (state_s == IDLE)) begin
            done_s = 1'b1;
        end else begin
            done_s = 1'b0;
        end
    end

    // One-hot gate decode of the stored address; out-of-range addresses decode to no gate.
    always_comb begin
        dec_s = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_r == ADDR_W'(i)) begin
                dec_s[i] = 1'b1;
            end else begin
                dec_s[i] = 1'b0;
            end
        end
    end

    // State register and registered latch-control outputs, derived from the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= IDLE;
            cnt_r         <= {CNT_W{1'b0}};
            addr_r        <= {ADDR_W{1'b0}};
            latch_d       <= {WIDTH{1'b0}};
            latch_gate    <= {DEPTH{1'b0}};
            latch_reset_b <= 1'b0;
            req_ready     <= 1'b0;
            done          <= 1'b0;
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            if (accept_s) begin
                addr_r  <= req_addr;
                latch_d <= req_data;
            end
            latch_gate    <= (state_s == PULSE) ? dec_s : {DEPTH{1'b0}};
            latch_reset_b <= (state_s != CLEAR);
            req_ready     <= (state_s == IDLE);
            done          <= done_s;
        end
    end

`ifdef LATCH_BANK_WRITER_VERIFY_EN
    logic [WIDTH-1:0] sel_word_s;
    logic             in_range_s;

    // Select the read-back word for the stored address, if that address is in range.
    always_comb begin
        sel_word_s = {WIDTH{1'b0}};
        in_range_s = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (addr_r == ADDR_W'(i)) begin
                sel_word_s = latch_q[i*WIDTH +: WIDTH];
                in_range_s = 1'b1;
            end else begin
                in_range_s = in_range_s;
            end
        end
    end

    // Sticky verify flag: set by a read-back mismatch, or re-evaluated when a clear completes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            verify_err <= 1'b0;
        end else if ((state_r == HOLD) && (state_s == IDLE)) begin
            if (in_range_s && (sel_word_s != latch_d)) begin
                verify_err <= 1'b1;
            end
        end else if ((state_r == CLEAR) && (state_s == IDLE)) begin
            verify_err <= |latch_q;
        end
    end
`endif

endmodule

// File: tb/tb_latch_bank_writer.sv
module tb_latch_bank_writer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    int         total = 0;
    int         bad = 0;
    int         viol = 0;

    // DUT 1: default parameters
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [1:0] req_addr = 2'd0;
    logic [7:0] req_data = 8'h00;
    logic       clr_req = 1'b0;
    logic [7:0] latch_d;
    logic [3:0] latch_gate;
    logic       latch_reset_b;
    logic       done;
    logic [7:0] mem [4];

    // DUT 2: SETUP/PULSE/HOLD = 2/3/2, DEPTH = 3
    logic       v2 = 1'b0;
    logic       rdy2;
    logic [1:0] a2 = 2'd0;
    logic [7:0] d2 = 8'h00;
    logic [7:0] latch_d2;
    logic [2:0] gate2;
    logic       rstb2;
    logic       done2;

`ifdef LATCH_BANK_WRITER_VERIFY_EN
    logic        stuck = 1'b0;
    logic [31:0] q_bus;
    logic        verify_err;
    logic        verify_err2;
    assign q_bus = {mem[3], mem[2], mem[1][7:1], mem[1][0] & ~stuck, mem[0]};
`endif

    always #5 clk = ~clk;

    latch_bank_writer u_dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_data(req_data), .clr_req(clr_req),
        .latch_d(latch_d), .latch_gate(latch_gate), .latch_reset_b(latch_reset_b),
`ifdef LATCH_BANK_WRITER_VERIFY_EN
        .latch_q(q_bus), .verify_err(verify_err),
`endif
        .done(done)
    );

    latch_bank_writer #(
        .WIDTH(8), .DEPTH(3), .ADDR_W(2),
        .SETUP_CYC(2), .PULSE_CYC(3), .HOLD_CYC(2)
    ) u_dut2 (
        .clk(clk), .rst(rst),
        .req_valid(v2), .req_ready(rdy2),
        .req_addr(a2), .req_data(d2), .clr_req(1'b0),
        .latch_d(latch_d2), .latch_gate(gate2), .latch_reset_b(rstb2),
`ifdef LATCH_BANK_WRITER_VERIFY_EN
        .latch_q(24'h000000), .verify_err(verify_err2),
`endif
        .done(done2)
    );

    // Behavioural latch bank: outputs are flops, so sampling mid-cycle is enough
    always @(negedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (!latch_reset_b) mem[i] <= 8'h00;
            else if (latch_gate[i]) mem[i] <= latch_d;
        end
    end

    // Safety monitor: at most one gate, never a gate together with RESET_B low
    always @(negedge clk) begin
        if (!rst) begin
            if ($countones(latch_gate) > 1) viol <= viol + 1;
            if ((latch_gate != 4'b0000) && !latch_reset_b) viol <= viol + 1;
            if ($countones(gate2) > 1) viol <= viol + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write on DUT 1 with default timing. On return it is the done cycle.
    task automatic write1(input logic [1:0] a, input logic [7:0] d);
        chk("wr_ready", req_ready, 1);
        req_valid = 1'b1; req_addr = a; req_data = d;
        tick();
        req_valid = 1'b0;
        tick(); tick(); tick();
        chk("wr_done", done, 1);
    endtask

    initial begin
        // Reset
        tick(); tick(); tick();
        chk("rst_rstb", latch_reset_b, 0);
        chk("rst_gate", latch_gate, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        tick();
        chk("rel_rstb", latch_reset_b, 1);
        chk("rel_ready", req_ready, 1);
        chk("rel_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h0);

        // Single write addr2 = A5
        req_valid = 1'b1; req_addr = 2'd2; req_data = 8'hA5;
        tick();                                   // cycle 1
        req_valid = 1'b0;
        chk("w1_d_c1", latch_d, 8'hA5);
        chk("w1_gate_c1", latch_gate, 4'b0000);
        chk("w1_ready_c1", req_ready, 0);
        tick();                                   // cycle 2
        chk("w1_gate_c2", latch_gate, 4'b0100);
        chk("w1_done_c2", done, 0);
        tick();                                   // cycle 3
        chk("w1_gate_c3", latch_gate, 4'b0000);
        chk("w1_d_c3", latch_d, 8'hA5);
        chk("w1_done_c3", done, 0);
        tick();                                   // cycle 4
        chk("w1_done_c4", done, 1);
        chk("w1_ready_c4", req_ready, 1);
        tick();
        chk("w1_done_c5", done, 0);
        chk("w1_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h00A50000);

        // Back-to-back writes with valid held
        req_valid = 1'b1; req_addr = 2'd0; req_data = 8'h11;
        tick();
        req_addr = 2'd3; req_data = 8'hFF;        // ignored while busy
        chk("bb_d1_c1", latch_d, 8'h11);
        tick();
        chk("bb_gate1", latch_gate, 4'b0001);
        chk("bb_d1_c2", latch_d, 8'h11);
        tick();
        chk("bb_d1_c3", latch_d, 8'h11);
        tick();
        chk("bb_done1", done, 1);
        chk("bb_ready1", req_ready, 1);
        tick();
        req_valid = 1'b0;
        chk("bb_acc2", req_ready, 0);
        chk("bb_d2_c1", latch_d, 8'hFF);
        chk("bb_gate_c1", latch_gate, 4'b0000);
        tick();
        chk("bb_gate2", latch_gate, 4'b1000);
        tick();
        chk("bb_d2_c3", latch_d, 8'hFF);
        tick();
        chk("bb_done2", done, 1);
        chk("bb_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'hFFA50011);

        // Clear wins over a simultaneous request
        clr_req = 1'b1; req_valid = 1'b1; req_addr = 2'd1; req_data = 8'h77;
        tick();
        clr_req = 1'b0;
        chk("clr_rstb", latch_reset_b, 0);
        chk("clr_ready", req_ready, 0);
        chk("clr_gate", latch_gate, 4'b0000);
        chk("clr_d_kept", latch_d, 8'hFF);
        tick();
        chk("clr_rstb_back", latch_reset_b, 1);
        chk("clr_done", done, 1);
        chk("clr_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h0);
        tick();
        req_valid = 1'b0;
        chk("clr_then_acc", latch_d, 8'h77);
        tick(); tick(); tick();
        chk("clr_w_done", done, 1);
        chk("clr_w_mem", mem[1], 8'h77);

        // DUT 2: 2/3/2 timing, addr 1
        v2 = 1'b1; a2 = 2'd1; d2 = 8'h3C;
        tick();
        v2 = 1'b0;
        chk("p_d", latch_d2, 8'h3C);
        for (int c = 1; c <= 9; c++) begin
            chk("p_gate", gate2, (c >= 3 && c <= 5) ? 32'h2 : 32'h0);
            chk("p_done", done2, (c == 8) ? 32'h1 : 32'h0);
            tick();
        end
        // DUT 2: out-of-range addr 3 with DEPTH 3
        v2 = 1'b1; a2 = 2'd3; d2 = 8'h5A;
        tick();
        v2 = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            chk("oor_gate", gate2, 0);
            chk("oor_done", done2, (c == 8) ? 32'h1 : 32'h0);
            tick();
        end

        // Async reset during PULSE
        req_valid = 1'b1; req_addr = 2'd2; req_data = 8'h5A;
        tick();
        req_valid = 1'b0;
        tick();
        chk("ar_gate_pre", latch_gate, 4'b0100);
        #2 rst = 1'b1;
        #1;
        chk("ar_gate_async", latch_gate, 4'b0000);
        chk("ar_rstb_async", latch_reset_b, 0);
        tick();
        chk("ar_done_a", done, 0);
        rst = 1'b0;
        tick();
        chk("ar_done_b", done, 0);
        chk("ar_ready", req_ready, 1);
        chk("ar_mem", {mem[3], mem[2], mem[1], mem[0]}, 32'h0);
        tick(); tick();
        chk("ar_done_c", done, 0);

`ifdef LATCH_BANK_WRITER_VERIFY_EN
        chk("ve_init", verify_err, 0);
        stuck = 1'b1;
        write1(2'd1, 8'h01);
        chk("ve_set", verify_err, 1);
        tick();
        write1(2'd0, 8'h22);
        chk("ve_sticky", verify_err, 1);
        stuck = 1'b0;
        tick();
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        tick();
        chk("ve_clr_done", done, 1);
        chk("ve_cleared", verify_err, 0);
        tick();
`else
        write1(2'd3, 8'hC3);
        tick();
        chk("fin_mem", mem[3], 8'hC3);
`endif

        chk("safety_viol", viol, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
